// File: rtl/mcp3201_sample_sched_pkg.sv
// Shared sizing, FSM state type and helpers for the MCP3201 sample scheduler.
package mcp3201_pkg;
    localparam int PERIOD_W     = 24;
    localparam int ADC_W        = 12;
    localparam int MAX_AVG_LOG2 = 7;
    localparam int TIMEOUT      = 4096;
    localparam int ACC_W        = ADC_W + MAX_AVG_LOG2;
    localparam int TIMEOUT_W    = $clog2(TIMEOUT + 1);
    localparam int CNT_W        = MAX_AVG_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_DATA, ACC, OUT, DRAIN} state_t;

    function automatic logic [2:0] clamp_avg(input logic [2:0] v);
        return (int'(v) > MAX_AVG_LOG2) ? 3'(MAX_AVG_LOG2) : v;
    endfunction
endpackage

// File: rtl/mcp3201_sample_sched_if.sv
// Reader handshake and result stream bundled between the scheduler and its neighbours.
interface mcp3201_sample_sched_if;
    import mcp3201_pkg::*;

    logic             adc_start;
    logic             adc_busy;
    logic             adc_new_data;
    logic [ADC_W-1:0] adc_data;
    logic [ADC_W-1:0] sample_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output adc_start, sample_data, sample_valid,
        input  adc_busy, adc_new_data, adc_data, sample_ready
    );

    modport slave (
        input  adc_start, sample_data, sample_valid,
        output adc_busy, adc_new_data, adc_data, sample_ready
    );
endinterface

// File: rtl/mcp3201_sample_sched_sync_rise_det.sv
// Two-flop synchronizer with a registered rising-edge pulse for slow-domain levels.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);
    logic r_s1, r_s2, r_s3, r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_rise;
endmodule

// File: rtl/mcp3201_sample_sched.sv
// Periodic MCP3201 conversion scheduler: tick timer, reader handshake FSM,
// 2^k averaging and a valid/ready result stream with sticky error flags.
module mcp3201_sample_sched
    import mcp3201_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_enable,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [2:0]          i_avg_log2,
    input  logic                i_err_clr,
    output logic                o_tick_miss,
    output logic                o_overrun,
    output logic                o_timeout_err,
    mcp3201_sample_sched_if.master bus
);
    // state     | meaning
    // IDLE      | waiting for a tick
    // ARM       | adc_start held until the reader reports busy
    // WAIT_DATA | waiting for the new_data rising edge, then accumulate
    // ACC       | decide whether the averaging group is complete
    // OUT       | publish acc >> avg and restart the group
    // DRAIN     | waiting for the reader to drop busy
    localparam logic [TIMEOUT_W-1:0] PHASE_LOAD = TIMEOUT_W'(TIMEOUT - 1);

    logic                w_busy, w_busy_rise, w_nd, w_nd_rise, w_unused;
    logic [PERIOD_W-1:0] r_timer, w_period_eff;
    logic                r_tick, r_en_d;
    state_t              r_state;
    logic [TIMEOUT_W-1:0] r_phase;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_count, w_group_n;
    logic [2:0]          r_avg_lat;
    logic [ADC_W-1:0]    r_data, w_avg;
    logic                r_start, r_valid, r_tick_miss, r_overrun, r_timeout_err;
    logic                w_timeout;

    sync_rise_det u_sync_busy (
        .clk(clk), .rst_n(rst_n), .i_d(bus.adc_busy), .o_level(w_busy), .o_rise(w_busy_rise)
    );
    sync_rise_det u_sync_nd (
        .clk(clk), .rst_n(rst_n), .i_d(bus.adc_new_data), .o_level(w_nd), .o_rise(w_nd_rise)
    );
    assign w_unused = w_busy_rise | w_nd;

    assign w_period_eff = (i_period < PERIOD_W'(2)) ? PERIOD_W'(2) : i_period;

    // Down-counter loaded with the period on every tick; the enable rising edge ticks at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_tick  <= 1'b0;
            r_en_d  <= 1'b0;
        end else begin
            r_en_d <= i_enable;
            r_tick <= 1'b0;
            if (!i_enable) begin
                r_timer <= '0;
            end else if (!r_en_d || r_timer == PERIOD_W'(1)) begin
                r_tick  <= 1'b1;
                r_timer <= w_period_eff;
            end else begin
                r_timer <= r_timer - PERIOD_W'(1);
            end
        end
    end

    assign w_avg     = ADC_W'(r_acc >> r_avg_lat);
    assign w_group_n = CNT_W'(1) << r_avg_lat;
    assign w_timeout = (r_phase == '0) && (r_state inside {ARM, WAIT_DATA, DRAIN});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_phase       <= '0;
            r_acc         <= '0;
            r_count       <= '0;
            r_avg_lat     <= '0;
            r_data        <= '0;
            r_start       <= 1'b0;
            r_valid       <= 1'b0;
            r_tick_miss   <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_phase <= (r_phase != '0) ? r_phase - TIMEOUT_W'(1) : '0;
            if (i_err_clr) begin
                r_tick_miss   <= 1'b0;
                r_overrun     <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            // Set events are assigned after the clear so they win in the same cycle.
            if (r_tick && r_state != IDLE) r_tick_miss <= 1'b1;
            if (r_valid && bus.sample_ready) r_valid <= 1'b0;

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
                r_start       <= 1'b0;
                r_acc         <= '0;
                r_count       <= '0;
                r_state       <= IDLE;
                r_phase       <= PHASE_LOAD;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!i_enable) begin
                            r_acc   <= '0;
                            r_count <= '0;
                        end else if (r_tick) begin
                            r_state <= ARM;
                            r_start <= 1'b1;
                            r_phase <= PHASE_LOAD;
                            if (r_count == '0) r_avg_lat <= clamp_avg(i_avg_log2);
                        end
                    end
                    ARM: if (w_busy) begin
                        r_start <= 1'b0;
                        r_state <= WAIT_DATA;
                        r_phase <= PHASE_LOAD;
                    end
                    WAIT_DATA: if (w_nd_rise) begin
                        r_acc   <= r_acc + ACC_W'(bus.adc_data);
                        r_count <= r_count + CNT_W'(1);
                        r_state <= ACC;
                        r_phase <= PHASE_LOAD;
                    end
                    ACC: begin
                        r_state <= (r_count == w_group_n) ? OUT : DRAIN;
                        r_phase <= PHASE_LOAD;
                    end
                    OUT: begin
                        r_data  <= w_avg;
                        r_valid <= 1'b1;
                        if (r_valid && !bus.sample_ready) r_overrun <= 1'b1;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= DRAIN;
                        r_phase <= PHASE_LOAD;
                    end
                    DRAIN: if (!w_busy) begin
                        r_state <= IDLE;
                        r_phase <= PHASE_LOAD;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.adc_start    = r_start;
    assign bus.sample_data  = r_data;
    assign bus.sample_valid = r_valid;
    assign o_tick_miss      = r_tick_miss;
    assign o_overrun        = r_overrun;
    assign o_timeout_err    = r_timeout_err;
endmodule

// File: tb/tb_mcp3201_sample_sched.sv
// Bench for mcp3201_sample_sched: behavioural reader model, averaging vector table
// and directed sequences for reset, tick misses, overrun and reader timeout.
module tb_mcp3201_sample_sched;
    import mcp3201_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                enable, err_clr;
    logic [PERIOD_W-1:0] period;
    logic [2:0]          avg_log2;
    logic                tick_miss, overrun, timeout_err;

    mcp3201_sample_sched_if bus();

    mcp3201_sample_sched dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_period(period),
        .i_avg_log2(avg_log2), .i_err_clr(err_clr), .o_tick_miss(tick_miss),
        .o_overrun(overrun), .o_timeout_err(timeout_err), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reader model: busy 4 clk after start, new_data 60 clk later, busy drops 2 clk after.
    logic        model_dead = 1'b0;
    logic [11:0] model_val  = 12'h5A5;
    logic [11:0] model_q[$];
    int          conv_cnt = 0;
    int          nd_cyc = 0;

    initial begin
        bus.adc_busy     = 1'b0;
        bus.adc_new_data = 1'b0;
        bus.adc_data     = '0;
        forever begin
            @(posedge clk);
            if (bus.adc_start === 1'b1 && !model_dead) begin
                repeat (4) @(posedge clk);
                #1 bus.adc_busy = 1'b1;
                repeat (60) @(posedge clk);
                #1;
                if (model_q.size() > 0) bus.adc_data = model_q.pop_front();
                else bus.adc_data = model_val;
                bus.adc_new_data = 1'b1;
                nd_cyc = cyc;
                conv_cnt++;
                repeat (2) @(posedge clk);
                #1 bus.adc_busy = 1'b0;
                repeat (6) @(posedge clk);
                #1 bus.adc_new_data = 1'b0;
            end
        end
    end

    int          start_cnt = 0, out_cnt = 0;
    int          last_start_cyc = 0, prev_start_cyc = 0;
    int          last_lat = 0, conv_at_out = 0;
    logic [11:0] last_data = '0;
    logic        prev_start = 1'b0, prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.adc_start && !prev_start) begin
            start_cnt++;
            prev_start_cyc = last_start_cyc;
            last_start_cyc = cyc;
        end
        prev_start = bus.adc_start;
        if (bus.sample_valid && !prev_valid) begin
            out_cnt++;
            last_data   = bus.sample_data;
            last_lat    = cyc - nd_cyc;
            conv_at_out = conv_cnt;
        end
        prev_valid = bus.sample_valid;
    end

    task automatic wait_out(input int base, input int budget, input string name);
        int i = 0;
        while (out_cnt == base && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (out_cnt == base) begin
            errors++;
            $display("FAIL %s: no sample_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0]  avg;
        logic [11:0] v0, v1, v2, v3;
        logic [11:0] expd;
    } vec_t;

    vec_t        vecs[7];
    logic [11:0] vals[4];
    int          ob, cb, sb, n, first_cyc;
    logic        seen1, seen0;

    initial begin
        vecs[0] = '{avg: 3'd2, v0: 12'd100,  v1: 12'd200,  v2: 12'd300,  v3: 12'd400,  expd: 12'd250};
        vecs[1] = '{avg: 3'd0, v0: 12'hABC,  v1: 12'h000,  v2: 12'h000,  v3: 12'h000,  expd: 12'hABC};
        vecs[2] = '{avg: 3'd0, v0: 12'h000,  v1: 12'h000,  v2: 12'h000,  v3: 12'h000,  expd: 12'h000};
        vecs[3] = '{avg: 3'd0, v0: 12'hFFF,  v1: 12'h000,  v2: 12'h000,  v3: 12'h000,  expd: 12'hFFF};
        vecs[4] = '{avg: 3'd1, v0: 12'h001,  v1: 12'h002,  v2: 12'h000,  v3: 12'h000,  expd: 12'h001};
        vecs[5] = '{avg: 3'd2, v0: 12'hFFF,  v1: 12'hFFF,  v2: 12'hFFF,  v3: 12'hFFF,  expd: 12'hFFF};
        vecs[6] = '{avg: 3'd1, v0: 12'hFFF,  v1: 12'hFFE,  v2: 12'h000,  v3: 12'h000,  expd: 12'hFFE};

        rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; period = 24'd2000; avg_log2 = 3'd0;
        bus.sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", bus.adc_start, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_data", bus.sample_data, 0);
        check("rst_flags", {tick_miss, overrun, timeout_err}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Reset in the middle of a conversion.
        @(negedge clk) enable = 1'b1;
        for (int i = 0; i < 50 && !bus.adc_busy; i++) @(negedge clk);
        check("midconv_busy", bus.adc_busy, 1);
        rst_n = 1'b0; enable = 1'b0;
        #1 check("midrst_start_async", bus.adc_start, 0);
        repeat (3) @(negedge clk);
        check("midrst_outputs", {bus.adc_start, bus.sample_valid, bus.sample_data, tick_miss, overrun, timeout_err}, 0);
        rst_n = 1'b1;
        sb = start_cnt;
        repeat (300) @(negedge clk);
        check("no_start_wo_enable", start_cnt - sb, 0);

        // Steady sampling: period 2000, single-sample averaging.
        model_val = 12'hABC;
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ob = out_cnt;
            wait_out(ob, 2500, "steady_wait");
            check("steady_data", last_data, 12'hABC);
            check("steady_latency", last_lat, 6);
            if (k > 0) check("tick_period", last_start_cyc - prev_start_cyc, 2000);
        end
        check("steady_flags", {tick_miss, overrun, timeout_err}, 0);
        enable = 1'b0;
        repeat (250) @(negedge clk);

        // Partial group abandoned by enable=0 must not leak into the next group.
        period = 24'd200; avg_log2 = 3'd2; model_val = 12'h5A5;
        model_q.delete();
        model_q.push_back(12'hFFF); model_q.push_back(12'hFFF);
        ob = out_cnt;
        enable = 1'b1;
        repeat (300) @(negedge clk);
        enable = 1'b0;
        repeat (250) @(negedge clk);
        check("partial_no_output", out_cnt - ob, 0);

        for (int i = 0; i < 7; i++) begin
            avg_log2 = vecs[i].avg;
            n = 1 << vecs[i].avg;
            vals = '{vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3};
            model_q.delete();
            for (int j = 0; j < n; j++) model_q.push_back(vals[j]);
            ob = out_cnt; cb = conv_cnt;
            enable = 1'b1;
            wait_out(ob, n * 200 + 400, "vec_wait");
            check("vec_data", last_data, vecs[i].expd);
            check("vec_conv_count", conv_at_out - cb, n);
            enable = 1'b0;
            repeat (250) @(negedge clk);
        end

        // Period shorter than a conversion: misses flagged, conversions stay intact.
        avg_log2 = 3'd0; period = 24'd50; model_val = 12'h3C3; model_q.delete();
        ob = out_cnt;
        enable = 1'b1;
        repeat (500) @(negedge clk);
        check("miss_flag", tick_miss, 1);
        check("miss_outputs_ge4", (out_cnt - ob) >= 4, 1);
        check("miss_data", last_data, 12'h3C3);
        check("miss_other_flags", {overrun, timeout_err}, 0);
        err_clr = 1'b1; seen1 = 1'b0; seen0 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tick_miss) seen1 = 1'b1; else seen0 = 1'b1;
        end
        err_clr = 1'b0;
        check("miss_set_beats_clr", seen1, 1);
        check("miss_clr_works", seen0, 1);
        enable = 1'b0;
        repeat (250) @(negedge clk);

        // Overrun with the sink stalled.
        bus.sample_ready = 1'b0; period = 24'd200; model_val = 12'h5A5;
        model_q.delete();
        model_q.push_back(12'h111); model_q.push_back(12'h222);
        ob = out_cnt; cb = conv_cnt;
        enable = 1'b1;
        wait_out(ob, 400, "ovr_first_wait");
        check("ovr_first_data", last_data, 12'h111);
        check("ovr_first_no_flag", overrun, 0);
        for (int i = 0; i < 800 && conv_cnt < cb + 2; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_data", bus.sample_data, 12'h222);
        check("ovr_valid_held", bus.sample_valid, 1);
        bus.sample_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", bus.sample_valid, 0);
        repeat (250) @(negedge clk);
        pulse_clr();
        check("clr_all_flags", {tick_miss, overrun, timeout_err}, 0);

        // Reader never answers: ARM times out after TIMEOUT cycles and retries on the next tick.
        model_dead = 1'b1; period = 24'd5000;
        enable = 1'b1;
        for (int i = 0; i < 50 && !bus.adc_start; i++) @(negedge clk);
        check("to_start_seen", bus.adc_start, 1);
        first_cyc = cyc;
        n = bus.adc_start ? 1 : 0;
        while (n > 0 && n < 6000) begin
            @(negedge clk);
            if (!bus.adc_start) break;
            n++;
        end
        check("to_start_len", n, TIMEOUT);
        check("to_flag", timeout_err, 1);
        check("to_no_output", bus.sample_valid, 0);
        for (int i = 0; i < 1500 && !bus.adc_start; i++) @(negedge clk);
        check("to_retry_interval", cyc - first_cyc, 5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcp3201_sample_sched.md
Name: mcp3201_sample_sched

Overview:
Periodic sampling controller for the MCP3201 SPI reader. It issues conversion requests at a programmable rate and follows the reader's start/busy/new_data handshake, which runs from a divided clock. It averages 2^k results and presents them on a valid/ready stream. It sits between the ADC reader and the downstream filter/logging path and reports scheduling misses, backpressure overwrites and a stalled reader.

Parameters:
PERIOD_W, 24, width of the sample-period register in clk cycles
ADC_W, 12, ADC result width
MAX_AVG_LOG2, 7, largest averaging exponent; accumulator is ADC_W+MAX_AVG_LOG2 bits
TIMEOUT, 4096, clk cycles allowed per handshake phase before abort

Ports:
clk  in  1  system clock, same clock that drives the reader's divider
rst_n  in  1  asynchronous active-low reset
enable  in  1  run scheduling; low = stop after any in-flight conversion
period  in  PERIOD_W  clk cycles between conversion ticks; values below 2 are treated as 2
avg_log2  in  3  average 2^avg_log2 conversions per output, latched at the start of each averaging group
adc_start  out  1  conversion request to the reader
adc_busy  in  1  reader busy, from the slow-clock domain
adc_new_data  in  1  reader data-available level, from the slow-clock domain
adc_data  in  ADC_W  reader result, stable while adc_new_data is high
sample_data  out  ADC_W  averaged result
sample_valid  out  1  sample_data valid
sample_ready  in  1  downstream accept
tick_miss  out  1  sticky: a tick arrived while a conversion was in flight
overrun  out  1  sticky: a result was overwritten while not accepted
timeout_err  out  1  sticky: the reader failed to respond
err_clr  in  1  clears all three sticky flags; a set event in the same cycle wins

Behaviour:
- Reset (async, rst_n=0): every output is 0, FSM is IDLE, timer is 0, accumulator and sample count are 0.
- adc_busy and adc_new_data each pass through a 2-flop synchronizer followed by a rising-edge detector. Edge pulses occur 3 clk after the pin edge.
- Period timer:
  - While enable=0 the timer holds at 0.
  - On the enable 0->1 transition a tick fires on the next cycle.
  - Further ticks fire every max(period,2) cycles.
  - A period change takes effect at the next reload.
- FSM:
  - IDLE: a tick moves to ARM.
  - ARM: adc_start=1 and held until synced busy=1. This covers the reader sampling start only on its slow clock. Then go to WAIT_DATA.
  - WAIT_DATA: adc_start=0. On the new_data rising edge, add adc_data to the accumulator, increment the count, and go to ACC.
  - ACC:
    - If count == 2^avg_lat, go to OUT.
    - Otherwise go to DRAIN.
  - DRAIN: wait for synced busy=0, then go to IDLE.
  - OUT:
    - sample_data <= acc >> avg_lat and sample_valid <= 1.
    - Clear the accumulator and count, then go to DRAIN.
- A tick while the FSM is not IDLE is dropped and sets tick_miss. Ticks are never queued.
- Output stream:
  - sample_valid stays high until a cycle with sample_ready=1.
  - If OUT writes while sample_valid=1 and sample_ready=0, the new value replaces the old one and overrun is set.
  - If OUT writes in the same cycle as a ready handshake, the new value is taken with no overrun.
- Timeout:
  - A phase counter resets on every state change.
  - Reaching TIMEOUT in ARM, WAIT_DATA or DRAIN sets timeout_err, deasserts adc_start, discards the accumulator and count, and returns to IDLE.
- enable falling mid-conversion: the current conversion finishes through DRAIN. A partial average is discarded on return to IDLE with enable=0. A completed OUT is still delivered.
- avg_log2 > MAX_AVG_LOG2 is clamped to MAX_AVG_LOG2. The accumulator never wraps.
- Result latency: the OUT write occurs 5 clk after the new_data pin edge (sync 2 + edge 1 + ACC 1 + OUT 1); sample_valid is asserted the following cycle.

Decomposition:
- Package mcp3201_pkg holds:
  - the FSM state enum IDLE/ARM/WAIT_DATA/ACC/OUT/DRAIN
  - ADC_W and ACC_W = ADC_W+MAX_AVG_LOG2
  - TIMEOUT_W = clog2(TIMEOUT+1)
- Sub-module sync_rise_det: 2-flop synchronizer plus registered rising-edge pulse, with async active-low reset. It is instantiated twice, for busy and new_data.

Test Plan:
- Reset mid-conversion with rst_n low for 3 clk -> all outputs 0, adc_start=0. After release, no start occurs until enable rises.
- enable=1, period=2000, avg_log2=0, ADC model returns 0xABC -> adc_start pulses once per 2000 clk. Each time, sample_data=0xABC and sample_valid is asserted 6 clk after the new_data pin edge. No flags set.
- avg_log2=2, model returns 100, 200, 300, 400 -> exactly one output, value 250 (0x0FA), after the 4th conversion. The next group starts again from zero.
- period=50, shorter than one conversion -> tick_miss=1 and conversions remain back-to-back and well-formed. err_clr together with a new miss leaves tick_miss=1.
- sample_ready=0, avg_log2=0, two conversions of 0x111 then 0x222 -> overrun=1 and sample_data=0x222. When ready rises, sample_valid drops after one cycle.
- Reader busy stuck at 0 -> after TIMEOUT=4096 cycles in ARM, timeout_err=1 and adc_start=0. The FSM returns to IDLE and retries on the next tick.
